transport_receive: RTL and testbench
====================================

# transport_receive

Receive-side transport stage, directly downstream of the byte link that carries packets produced by `transportSend`. It consumes the framed byte stream one packet at a time, checks the header, trailer and padding, and passes the payload on. Control packets yield one 16-bit control word. Audio packets yield 16-bit samples through a small output FIFO to the audio consumer. Malformed or truncated packets are reported and dropped.

## Interface
- `packetSize`, 16: bytes per packet. Must be even and ≥ 4.
- `FIFO_DEPTH`, 8: audio sample FIFO depth. Power of two.
- `clk` in 1: clock. Already decided.
- `reset` in 1: reset, synchronous, active-high. Already decided.
- `rx_byte` in 8: incoming packet byte.
- `rx_valid` in 1: `rx_byte` is valid this cycle.
- `rx_frame` in 1: high for the whole duration of a packet (the upstream `sending`).
- `ctrl_data` out 16: last received control word. Holds its value until the next control word.
- `ctrl_valid` out 1: one-cycle pulse; `ctrl_data` is new.
- `audio_data` out 16: head of the audio FIFO.
- `audio_valid` out 1: FIFO not empty.
- `audio_ready` in 1: consumer pops the head when `audio_valid & audio_ready`.
- `pkt_error` out 1: one-cycle pulse; the current packet was rejected.
- `err_code` out 2: cause, valid with `pkt_error`. 01 = bad header, 10 = bad padding or bad trailer, 11 = truncated packet.
- `overflow` out 1: sticky. A sample was dropped because the FIFO was full. Cleared only by `reset`.
- `busy` out 1: high while a packet is in progress (state ≠ IDLE).

## Operation
- **Packet formats.** All multi-byte values are MSB first.
  - Control packet: header 0x40, then `data[15:8]`, then `data[7:0]`, then `packetSize-3` zero bytes.
  - Audio packet: header 0x80, then `(packetSize-2)/2` samples of two bytes each (high byte, low byte), then trailer 0xFF.
- **Byte acceptance.** A byte is accepted only when `rx_valid && rx_frame`. A byte counter (`$clog2(packetSize+1)` bits) counts accepted bytes within the packet.
- **FSM states:** IDLE, CTRL_HI, CTRL_LO, CTRL_PAD, AUD_HI, AUD_LO, AUD_TRL, DISCARD.
- **IDLE.** The first accepted byte is the header.
  - 0x40 → CTRL_HI.
  - 0x80 → AUD_HI.
  - Any other value → `pkt_error`, code 01, then DISCARD.
- **CTRL_HI → CTRL_LO → CTRL_PAD.** The two data bytes are latched into a holding register.
  - CTRL_PAD checks every pad byte for zero. On the final byte (count = `packetSize`), `ctrl_data` is loaded and `ctrl_valid` is pulsed, then the FSM returns to IDLE.
  - Any nonzero pad byte → code 10, DISCARD. No `ctrl_valid`.
  - If `packetSize` = 4, CTRL_PAD receives exactly one pad byte.
- **AUD_HI / AUD_LO.** These alternate. On each low byte, `{hi, lo}` is pushed to the FIFO.
  - After `packetSize-2` payload bytes, the FSM moves to AUD_TRL.
  - Trailer 0xFF → IDLE.
  - Any other trailer value → code 10. Samples already pushed stay in the FIFO; they are not retracted.
- **FIFO full on push.** If the FIFO is full and no pop happens in the same cycle, the sample is dropped and `overflow` is set. If a pop happens in the same cycle as the push, the push succeeds.
- **Truncation.** `rx_frame` falling while the state is neither IDLE nor DISCARD → `pkt_error`, code 11, then IDLE.
- **DISCARD.** Ignores bytes until `rx_frame` is low, then returns to IDLE.
- **Excess bytes.** Bytes that arrive after a complete packet while `rx_frame` is still high are ignored silently. The FSM goes to DISCARD with no error.
- **Reset.** Resets mid-packet: FSM to IDLE, FIFO emptied, counter cleared, and the partial packet is lost.

## Timing
- **Reset values:** `ctrl_data` 0, `ctrl_valid` 0, `audio_valid` 0, `audio_data` 0, `pkt_error` 0, `err_code` 00, `overflow` 0, `busy` 0.
- **`ctrl_valid`:** asserted in the cycle after the last pad byte is accepted.
- **Audio sample latency:** a sample is pushed in the cycle after its low byte is accepted. `audio_valid` rises one cycle after the push (registered FIFO status). Total: 2 cycles from the low byte to `audio_valid`.
- **`pkt_error` / `err_code`:** registered; asserted in the cycle after the offending byte, or after the `rx_frame` fall.
- **Throughput:** full rate, one byte per cycle. Gaps in `rx_valid` within a frame are tolerated.
- **Pop:** a pop takes effect at the clock edge where `audio_valid & audio_ready`. The next sample appears on `audio_data` in the following cycle.

## Structure
- **Shared package (`transport_pkg`):**
  - Header constants `HDR_CTRL = 8'h40`, `HDR_AUDIO = 8'h80`, `TRAILER = 8'hFF`.
  - `cmd` encodings 00 / 01 / 10, shared with `transportSend`.
  - Error-code constants.
- **Sub-module:** one, `sample_fifo`. Synchronous FIFO with parameterised width and depth, sync reset, full/empty flags, and simultaneous read/write allowed.

## Test plan
- Control packet with data 0xBEEF and 13 zero pads → a single `ctrl_valid` pulse, `ctrl_data` = 0xBEEF, no error.
- Audio packet with samples 0x0001 through 0x0007 and trailer 0xFF, with `audio_ready` held high → seven samples out, in order, no error.
- Header 0x33 followed by 15 bytes → `pkt_error` with code 01, no outputs, and the next valid control packet is decoded correctly.
- Audio packet with trailer 0x00 → all 7 samples delivered, then `pkt_error` with code 10. Control packet with pad byte 0x01 → code 10, no `ctrl_valid`.
- `rx_frame` dropped after 5 bytes of an audio packet → 2 samples delivered, code 11, FSM back in IDLE, `busy` = 0.
- `audio_ready` held low across two audio packets (14 samples, `FIFO_DEPTH` = 8) → 8 samples retained, `overflow` = 1. Then raise `audio_ready` → 8 samples drained, and the sticky `overflow` flag remains set until reset.

Source files
------------

// File: rtl/transport_pkg.sv
// Shared framing constants for the transport send/receive pair.
package transport_pkg;

    localparam logic [7:0] HDR_CTRL  = 8'h40;
    localparam logic [7:0] HDR_AUDIO = 8'h80;
    localparam logic [7:0] TRAILER   = 8'hFF;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_CTRL  = 2'b01,
        CMD_AUDIO = 2'b10
    } cmd_e;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_HEADER = 2'b01;
    localparam logic [1:0] ERR_FORMAT = 2'b10;
    localparam logic [1:0] ERR_TRUNC  = 2'b11;

endpackage

// File: rtl/transport_receive_sample_fifo.sv
// Synchronous FIFO for decoded audio samples; registered occupancy drives the
// full/empty flags, and a read frees a slot for a write in the same cycle.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_rd, do_wr;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == FULL_CNT);
    assign do_rd     = rd_en_i && !empty_o;
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    assign rd_data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/transport_receive.sv
// Receive-side transport stage: parses framed control/audio packets, emits
// control words and audio samples, and reports malformed or truncated packets.
module transport_receive
    import transport_pkg::*;
#(
    parameter int packetSize = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        rx_frame,
    output logic [15:0] ctrl_data,
    output logic        ctrl_valid,
    output logic [15:0] audio_data,
    output logic        audio_valid,
    input  logic        audio_ready,
    output logic        pkt_error,
    output logic [1:0]  err_code,
    output logic        overflow,
    output logic        busy
);
    localparam int CW = $clog2(packetSize + 1);
    localparam logic [CW-1:0] IDX_LAST     = CW'(packetSize - 1);
    localparam logic [CW-1:0] IDX_LAST_PLD = CW'(packetSize - 2);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CTRL_HI  = 3'd1;
    localparam logic [2:0] ST_CTRL_LO  = 3'd2;
    localparam logic [2:0] ST_CTRL_PAD = 3'd3;
    localparam logic [2:0] ST_AUD_HI   = 3'd4;
    localparam logic [2:0] ST_AUD_LO   = 3'd5;
    localparam logic [2:0] ST_AUD_TRL  = 3'd6;
    localparam logic [2:0] ST_DISCARD  = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [15:0]   hold_q, hold_d;
    logic [15:0]   ctrl_data_q, ctrl_data_d;
    logic          ctrl_valid_q, ctrl_valid_d;
    logic          push_q, push_d;
    logic [15:0]   push_data_q, push_data_d;
    logic          pkt_error_q, pkt_error_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          overflow_q, overflow_d;

    logic accept;
    logic fifo_full, fifo_empty, pop;

    assign accept = rx_valid && rx_frame;

    // done_q marks a completed packet whose frame is still open; any further
    // bytes in that frame are excess and are dropped without an error.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        done_d       = done_q;
        hold_d       = hold_q;
        ctrl_data_d  = ctrl_data_q;
        ctrl_valid_d = 1'b0;
        push_d       = 1'b0;
        push_data_d  = push_data_q;
        pkt_error_d  = 1'b0;
        err_code_d   = ERR_NONE;

        if (!rx_frame) begin
            done_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    if (done_q) begin
                        state_d = ST_DISCARD;
                    end else begin
                        cnt_d = CW'(1);
                        if (rx_byte == HDR_CTRL) begin
                            state_d = ST_CTRL_HI;
                        end else if (rx_byte == HDR_AUDIO) begin
                            state_d = ST_AUD_HI;
                        end else begin
                            pkt_error_d = 1'b1;
                            err_code_d  = ERR_HEADER;
                            state_d     = ST_DISCARD;
                        end
                    end
                end
            end
            ST_DISCARD: begin
                cnt_d = '0;
                if (!rx_frame) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (!rx_frame) begin
                    pkt_error_d = 1'b1;
                    err_code_d  = ERR_TRUNC;
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                end else if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    case (state_q)
                        ST_CTRL_HI: begin
                            hold_d[15:8] = rx_byte;
                            state_d      = ST_CTRL_LO;
                        end
                        ST_CTRL_LO: begin
                            hold_d[7:0] = rx_byte;
                            state_d     = ST_CTRL_PAD;
                        end
                        ST_CTRL_PAD: begin
                            if (rx_byte != 8'h00) begin
                                pkt_error_d = 1'b1;
                                err_code_d  = ERR_FORMAT;
                                state_d     = ST_DISCARD;
                            end else if (cnt_q == IDX_LAST) begin
                                ctrl_data_d  = hold_q;
                                ctrl_valid_d = 1'b1;
                                done_d       = 1'b1;
                                state_d      = ST_IDLE;
                            end
                        end
                        ST_AUD_HI: begin
                            hold_d[15:8] = rx_byte;
                            state_d      = ST_AUD_LO;
                        end
                        ST_AUD_LO: begin
                            push_d      = 1'b1;
                            push_data_d = {hold_q[15:8], rx_byte};
                            state_d     = (cnt_q == IDX_LAST_PLD) ? ST_AUD_TRL : ST_AUD_HI;
                        end
                        ST_AUD_TRL: begin
                            if (rx_byte == TRAILER) begin
                                done_d  = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                pkt_error_d = 1'b1;
                                err_code_d  = ERR_FORMAT;
                                state_d     = ST_DISCARD;
                            end
                        end
                        default: state_d = ST_DISCARD;
                    endcase
                end
            end
        endcase
    end

    assign pop        = audio_valid && audio_ready;
    assign overflow_d = overflow_q || (push_q && fifo_full && !pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            hold_q       <= '0;
            ctrl_data_q  <= '0;
            ctrl_valid_q <= 1'b0;
            push_q       <= 1'b0;
            push_data_q  <= '0;
            pkt_error_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            hold_q       <= hold_d;
            ctrl_data_q  <= ctrl_data_d;
            ctrl_valid_q <= ctrl_valid_d;
            push_q       <= push_d;
            push_data_q  <= push_data_d;
            pkt_error_q  <= pkt_error_d;
            err_code_q   <= err_code_d;
            overflow_q   <= overflow_d;
        end
    end

    sample_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (push_q),
        .wr_data_i (push_data_q),
        .rd_en_i   (pop),
        .rd_data_o (audio_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign audio_valid = !fifo_empty;
    assign ctrl_data   = ctrl_data_q;
    assign ctrl_valid  = ctrl_valid_q;
    assign pkt_error   = pkt_error_q;
    assign err_code    = err_code_q;
    assign overflow    = overflow_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_transport_receive.sv
// Directed bench for transport_receive: a packet table plus hand-timed sequences.
module tb_transport_receive;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_valid, rx_frame;
    logic [15:0] ctrl_data;
    logic        ctrl_valid;
    logic [15:0] audio_data;
    logic        audio_valid, audio_ready;
    logic        pkt_error;
    logic [1:0]  err_code;
    logic        overflow, busy;

    always #5 clk = ~clk;

    transport_receive #(.packetSize(16), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_frame(rx_frame),
        .ctrl_data(ctrl_data), .ctrl_valid(ctrl_valid), .audio_data(audio_data),
        .audio_valid(audio_valid), .audio_ready(audio_ready), .pkt_error(pkt_error),
        .err_code(err_code), .overflow(overflow), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge
    int          mon_ctrl_n, mon_err_n;
    logic [15:0] mon_ctrl_word;
    logic [1:0]  mon_code;
    logic [15:0] mon_q [$];

    always @(negedge clk) begin
        if (!reset) begin
            if (ctrl_valid) begin mon_ctrl_n++; mon_ctrl_word = ctrl_data; end
            if (pkt_error) begin mon_err_n++; mon_code = err_code; end
            if (audio_valid && audio_ready) mon_q.push_back(audio_data);
        end
    end

    task automatic clear_mon();
        mon_ctrl_n = 0; mon_err_n = 0; mon_code = 2'b00; mon_ctrl_word = '0;
        mon_q.delete();
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b; rx_valid = 1'b1; rx_frame = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [127:0] p, input int n, input logic gap);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            if (i < 16) b = p[8*(15-i) +: 8];
            else        b = 8'h80;
            send_byte(b);
            if (gap) tick();
        end
        rx_valid = 1'b0; rx_frame = 1'b0;
    endtask

    function automatic logic [127:0] ctrl_pkt(input logic [15:0] w, input int padidx, input logic [7:0] padval);
        logic [127:0] p;
        p = '0;
        p[127:120] = 8'h40;
        p[119:104] = w;
        if (padidx >= 3 && padidx < 16) p[8*(15-padidx) +: 8] = padval;
        return p;
    endfunction

    function automatic logic [127:0] audio_pkt(input logic [15:0] base, input logic [7:0] trl);
        logic [127:0] p;
        logic [15:0]  s;
        p = '0;
        p[127:120] = 8'h80;
        for (int k = 0; k < 7; k++) begin
            s = base + 16'(k);
            p[8*(14-2*k) +: 8] = s[15:8];
            p[8*(13-2*k) +: 8] = s[7:0];
        end
        p[7:0] = trl;
        return p;
    endfunction

    typedef struct packed {
        logic [127:0] pkt;
        logic [4:0]   nbytes;
        logic         gap;
        logic         ctrl_exp;
        logic [15:0]  ctrl_word;
        logic [3:0]   nsamp;
        logic [15:0]  samp_base;
        logic         err_exp;
        logic [1:0]   code;
    } vec_t;

    function automatic vec_t mk(input logic [127:0] p, input int n, input logic g, input logic ce,
                                input logic [15:0] cw, input int ns, input logic [15:0] sb,
                                input logic ee, input logic [1:0] c);
        vec_t v;
        v.pkt = p; v.nbytes = 5'(n); v.gap = g; v.ctrl_exp = ce; v.ctrl_word = cw;
        v.nsamp = 4'(ns); v.samp_base = sb; v.err_exp = ee; v.code = c;
        return v;
    endfunction

    vec_t vt [9];

    initial begin
        logic [127:0] p;

        vt[0] = mk(ctrl_pkt(16'hBEEF, 0, 8'h00),   16, 1'b0, 1'b1, 16'hBEEF, 0, 16'h0000, 1'b0, 2'b00);
        vt[1] = mk(audio_pkt(16'h0001, 8'hFF),     16, 1'b0, 1'b0, 16'h0000, 7, 16'h0001, 1'b0, 2'b00);
        vt[2] = mk({8'h33, 8'h40, 8'hBE, 8'hEF, 96'h0}, 16, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 1'b1, 2'b01);
        vt[3] = mk(ctrl_pkt(16'h1234, 0, 8'h00),   16, 1'b1, 1'b1, 16'h1234, 0, 16'h0000, 1'b0, 2'b00);
        vt[4] = mk(audio_pkt(16'h0100, 8'h00),     16, 1'b0, 1'b0, 16'h0000, 7, 16'h0100, 1'b1, 2'b10);
        vt[5] = mk(ctrl_pkt(16'h4321, 5, 8'h01),   16, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 1'b1, 2'b10);
        vt[6] = mk(ctrl_pkt(16'hA5C3, 0, 8'h00),   19, 1'b0, 1'b1, 16'hA5C3, 0, 16'h0000, 1'b0, 2'b00);
        vt[7] = mk(audio_pkt(16'h0001, 8'hFF),      5, 1'b0, 1'b0, 16'h0000, 2, 16'h0001, 1'b1, 2'b11);
        vt[8] = mk(ctrl_pkt(16'h7777, 0, 8'h00),    3, 1'b0, 1'b0, 16'h0000, 0, 16'h0000, 1'b1, 2'b11);

        reset = 1'b1; rx_byte = '0; rx_valid = 1'b0; rx_frame = 1'b0; audio_ready = 1'b0;
        clear_mon();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst ctrl_data", 32'(ctrl_data), 32'h0);
        chk("rst ctrl_valid", 32'(ctrl_valid), 32'h0);
        chk("rst audio_valid", 32'(audio_valid), 32'h0);
        chk("rst audio_data", 32'(audio_data), 32'h0);
        chk("rst pkt_error", 32'(pkt_error), 32'h0);
        chk("rst err_code", 32'(err_code), 32'h0);
        chk("rst overflow", 32'(overflow), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);

        for (int i = 0; i < 9; i++) begin
            audio_ready = 1'b1;
            clear_mon();
            send_pkt(vt[i].pkt, int'(vt[i].nbytes), vt[i].gap);
            repeat (8) tick();
            chk($sformatf("v%0d ctrl_count", i), 32'(mon_ctrl_n), 32'(vt[i].ctrl_exp));
            if (vt[i].ctrl_exp) chk($sformatf("v%0d ctrl_data", i), 32'(mon_ctrl_word), 32'(vt[i].ctrl_word));
            chk($sformatf("v%0d sample_count", i), 32'(mon_q.size()), 32'(vt[i].nsamp));
            for (int k = 0; k < int'(vt[i].nsamp) && k < mon_q.size(); k++)
                chk($sformatf("v%0d sample%0d", i, k), 32'(mon_q[k]), 32'(vt[i].samp_base + 16'(k)));
            chk($sformatf("v%0d err_count", i), 32'(mon_err_n), 32'(vt[i].err_exp));
            if (vt[i].err_exp) chk($sformatf("v%0d err_code", i), 32'(mon_code), 32'(vt[i].code));
            chk($sformatf("v%0d busy_after", i), 32'(busy), 32'h0);
        end

        // ctrl_valid lands exactly one cycle after the last pad byte
        clear_mon();
        p = ctrl_pkt(16'hC0DE, 0, 8'h00);
        for (int k = 0; k < 16; k++) begin
            send_byte(p[8*(15-k) +: 8]);
            if (k == 0) chk("ctrl busy mid", 32'(busy), 32'h1);
            if (k < 15) chk($sformatf("ctrl early%0d", k), 32'(ctrl_valid), 32'h0);
        end
        chk("ctrl pulse", 32'(ctrl_valid), 32'h1);
        chk("ctrl word", 32'(ctrl_data), 32'hC0DE);
        chk("ctrl busy done", 32'(busy), 32'h0);
        tick();
        chk("ctrl pulse end", 32'(ctrl_valid), 32'h0);
        chk("ctrl word held", 32'(ctrl_data), 32'hC0DE);
        rx_frame = 1'b0;
        repeat (2) tick();

        // Audio sample reaches audio_valid two cycles after its low byte
        clear_mon();
        audio_ready = 1'b0;
        p = audio_pkt(16'h1234, 8'hFF);
        for (int k = 0; k < 3; k++) send_byte(p[8*(15-k) +: 8]);
        chk("aud lat +1", 32'(audio_valid), 32'h0);
        tick();
        chk("aud lat +2", 32'(audio_valid), 32'h1);
        chk("aud lat data", 32'(audio_data), 32'h1234);
        for (int k = 3; k < 16; k++) send_byte(p[8*(15-k) +: 8]);
        rx_frame = 1'b0;
        tick();
        audio_ready = 1'b1;
        repeat (12) tick();
        chk("aud lat count", 32'(mon_q.size()), 32'd7);
        if (mon_q.size() == 7) chk("aud lat last", 32'(mon_q[6]), 32'h123A);
        chk("aud lat errs", 32'(mon_err_n), 32'h0);

        // Bad header: registered error pulse, then discard until frame drops
        send_byte(8'h33);
        chk("hdr err pulse", 32'(pkt_error), 32'h1);
        chk("hdr err code", 32'(err_code), 32'h1);
        chk("hdr busy", 32'(busy), 32'h1);
        tick();
        chk("hdr err end", 32'(pkt_error), 32'h0);
        rx_frame = 1'b0;
        repeat (2) tick();
        chk("hdr busy end", 32'(busy), 32'h0);

        // Overflow: 14 samples into an 8-deep FIFO with the consumer stalled
        clear_mon();
        audio_ready = 1'b0;
        send_pkt(audio_pkt(16'h0201, 8'hFF), 16, 1'b0);
        repeat (4) tick();
        chk("ovf before", 32'(overflow), 32'h0);
        send_pkt(audio_pkt(16'h0301, 8'hFF), 16, 1'b0);
        repeat (4) tick();
        chk("ovf set", 32'(overflow), 32'h1);
        chk("ovf none popped", 32'(mon_q.size()), 32'h0);
        audio_ready = 1'b1;
        repeat (12) tick();
        chk("ovf drained", 32'(mon_q.size()), 32'd8);
        for (int k = 0; k < 8 && k < mon_q.size(); k++)
            chk($sformatf("ovf sample%0d", k), 32'(mon_q[k]), (k < 7) ? 32'(16'h0201 + 16'(k)) : 32'h0301);
        chk("ovf empty", 32'(audio_valid), 32'h0);
        chk("ovf sticky", 32'(overflow), 32'h1);
        chk("ovf errs", 32'(mon_err_n), 32'h0);

        // Reset mid-packet with a sample in flight
        audio_ready = 1'b0;
        send_byte(8'h80); send_byte(8'h11); send_byte(8'h22);
        reset = 1'b1;
        tick();
        reset = 1'b0; rx_frame = 1'b0;
        tick();
        chk("mid rst busy", 32'(busy), 32'h0);
        chk("mid rst overflow", 32'(overflow), 32'h0);
        repeat (2) tick();
        chk("mid rst audio_valid", 32'(audio_valid), 32'h0);
        clear_mon();
        audio_ready = 1'b1;
        send_pkt(ctrl_pkt(16'h5A5A, 0, 8'h00), 16, 1'b0);
        repeat (6) tick();
        chk("mid rst ctrl count", 32'(mon_ctrl_n), 32'h1);
        chk("mid rst ctrl word", 32'(mon_ctrl_word), 32'h5A5A);
        chk("mid rst samples", 32'(mon_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
